lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit that drives the single-port data memory (word-addressed, 1024 words, read and write sampled on `clk`, read data registered) on behalf of the pipeline's MEM stage. It accepts one RV32I load or store per handshake and converts its byte address into a word index. It performs byte/halfword lane selection with sign or zero extension for loads. Sub-word stores become a read-modify-write, because the memory has no byte enables.

## Interface
- `WIDTH`, 32, data and address width; only 32 is supported.
- `DEPTH_LOG2`, 10, log2 of memory depth in words; `mem_address` upper bits above this are zero.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: LSU can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010).
- `req_addr` in WIDTH: byte address.
- `req_wdata` in WIDTH: store data; low byte/half used for SB/SH.
- `resp_valid` out 1: one-cycle completion pulse for every accepted request.
- `resp_rdata` out WIDTH: extended load data, valid with `resp_valid`; 0 for stores.
- `resp_misalign` out 1: misaligned-access flag, valid with `resp_valid`.
- `mem_address` out WIDTH: word index = `req_addr[DEPTH_LOG2+1:2]`, zero-extended.
- `mem_data_write` out WIDTH: full word to write.
- `mem_MemWrite` out 1: memory write strobe.
- `mem_MemRead` out 1: memory read strobe.
- `mem_data_read` in WIDTH: memory read data, valid the cycle after a `mem_MemRead` edge.

## Operation
- **Accept:** at the rising edge where `req_valid && req_ready`, latch the request and register the word index into `mem_address`. `mem_address` stays stable until the next accept.
- **State register:** encodes IDLE, READ, MERGE, WRITE, RESP. The memory strobes decode from this state only.
  - **IDLE:** `req_ready` = 1. On accept:
    - loads, SB, SH go to READ;
    - SW goes to WRITE with `mem_data_write` = `req_wdata`.
  - **READ:** `mem_MemRead` = 1, then go to MERGE.
  - **MERGE:** `mem_data_read` is valid.
    - Load: register the extended lane into `resp_rdata`, go to RESP.
    - Store: register the merged word into `mem_data_write`, go to WRITE.
  - **WRITE:** `mem_MemWrite` = 1, then go to RESP.
  - **RESP:** `resp_valid` = 1, then go to IDLE.
- `mem_MemRead` and `mem_MemWrite` are never high together and never high in IDLE, MERGE or RESP.
- **Lanes:** little-endian; byte k = bits [8k+7:8k], where k = `addr[1:0]`. Halfword lane = `addr[1]`.
- **Load extension:**
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes the word through.
- **Store merge:** SB/SH replace only the addressed byte/half of the read word; all other bits are preserved.
- **Undefined funct3:** loads 011/110/111 behave as LW; stores use `req_funct3[1:0]`, with 11 treated as SW.
- **Reset values:** state IDLE, `req_ready` = 1, and every other output 0 (`resp_valid`, `resp_rdata`, `resp_misalign`, `mem_address`, `mem_data_write`, `mem_MemRead`, `mem_MemWrite`).
- **Reset mid-operation:** aborts immediately. No pending write is issued, no response is produced, and memory keeps its prior contents for any RMW not yet in WRITE.

## Timing
- Cycle 0 is the first cycle after the accept edge.
- **Load:** READ in cycle 0, MERGE in cycle 1, `resp_valid` in cycle 2.
- **SW:** WRITE in cycle 0, `resp_valid` in cycle 1.
- **SB/SH:** READ in cycle 0, MERGE in cycle 1, WRITE in cycle 2, `resp_valid` in cycle 3.
- Next accept is possible at the first edge after RESP. Peak rate is one load per 4 cycles.
- `req_*` inputs are ignored while `req_ready` = 0; the requester holds them until accepted.
- `resp_rdata` and `resp_misalign` hold their values after `resp_valid` until the next RESP.

## Configuration
- **`LSU_MISALIGN_TRAP_EN` defined:** an access is misaligned when it is LH/LHU/SH with `addr[0]` = 1, or LW/SW with `addr[1:0]` != 0.
  - The accept goes directly to RESP with `resp_misalign` = 1 and `resp_rdata` = 0.
  - No memory strobe is raised; `resp_valid` appears in cycle 0.
- **Undefined:** `resp_misalign` is tied to 0.
  - Halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
  - The access proceeds normally on the aligned lane.

## Test plan
- **Loads from word 5 = 0x80FF7F01:**
  - LB @0x17 gives `resp_rdata` = 0xFFFFFF80 in cycle 2, `mem_address` = 5.
  - LBU @0x17 gives 0x00000080.
  - LH @0x16 gives 0xFFFF80FF.
  - LHU @0x14 gives 0x00007F01.
- **SB, then LW:** SB 0x000000AB @0x15 shows `mem_MemRead` in cycle 0 and `mem_MemWrite` in cycle 2 with `mem_data_write` = 0x80FFAB01. A following LW @0x14 returns 0x80FFAB01.
- **SW:** SW 0xDEADBEEF @0x20 shows `mem_MemWrite` in cycle 0 with `mem_address` = 8, no `mem_MemRead`, `resp_valid` in cycle 1, and `req_ready` low for cycles 0–1.
- **Back-to-back requests:** `req_valid` held high with two queued loads gives the second accept exactly 4 cycles after the first. Strobes are never high together.
- **Reset mid-RMW:** `reset` asserted during MERGE of SB 0x55 @0x15 returns all outputs to 0 asynchronously with no `mem_MemWrite`. LW @0x14 afterwards returns the unchanged 0x80FF7F01.
- **Misaligned LW @0x13:**
  - With `LSU_MISALIGN_TRAP_EN`: `resp_valid` in cycle 0, `resp_misalign` = 1, `resp_rdata` = 0, no strobes.
  - Without it: LW of word 4 with `resp_misalign` = 0.

Source files
------------

// File: rtl/lsu_mem_port_if.sv
// Request, response and data-memory signals between the MEM stage and lsu_mem_port.
// slave = the LSU side, master = the pipeline/memory side.
interface lsu_mem_port_if #(
  parameter int WIDTH = 32
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_misalign;
  logic [WIDTH-1:0] mem_address;
  logic [WIDTH-1:0] mem_data_write;
  logic             mem_MemWrite;
  logic             mem_MemRead;
  logic [WIDTH-1:0] mem_data_read;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_read,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_address, mem_data_write, mem_MemWrite, mem_MemRead
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_data_read,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
           mem_address, mem_data_write, mem_MemWrite, mem_MemRead
  );
endinterface

// File: rtl/lsu_mem_port.sv
// RV32I load/store unit for a single-port word memory; sub-word stores are read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses respond immediately with resp_misalign = 1.
module lsu_mem_port #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic          clk,
  input  logic          reset,
  lsu_mem_port_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_MERGE, S_WRITE, S_RESP} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [1:0]       size_q, size_d;
  logic             uns_q, uns_d;
  logic [1:0]       lane_q, lane_d;
  logic [15:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0] mem_address_q, mem_address_d;
  logic [WIDTH-1:0] mem_data_write_q, mem_data_write_d;
  logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic             resp_misalign_q, resp_misalign_d;

  logic [1:0]       req_size;
  logic             req_uns;
  logic             req_mis;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^bus.req_addr[WIDTH-1:DEPTH_LOG2+2];

  function automatic logic [WIDTH-1:0] load_ext(input logic [WIDTH-1:0] w, input logic [1:0] sz,
                                                input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: load_ext = uns ? {{(WIDTH-8){1'b0}}, b}  : {{(WIDTH-8){b[7]}}, b};
      SZ_HALF: load_ext = uns ? {{(WIDTH-16){1'b0}}, h} : {{(WIDTH-16){h[15]}}, h};
      default: load_ext = w;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] store_merge(input logic [WIDTH-1:0] w, input logic [1:0] sz,
                                                   input logic [1:0] lane, input logic [15:0] d);
    store_merge = w;
    if (sz == SZ_BYTE) store_merge[{lane, 3'b000} +: 8] = d[7:0];
    else               store_merge[{lane[1], 4'b0000} +: 16] = d;
  endfunction

  // Access size: stores only look at funct3[1:0]; undefined load encodings act as LW.
  always_comb begin
    req_size = SZ_WORD;
    if (bus.req_write) begin
      case (bus.req_funct3[1:0])
        2'b00:   req_size = SZ_BYTE;
        2'b01:   req_size = SZ_HALF;
        default: req_size = SZ_WORD;
      endcase
    end else begin
      case (bus.req_funct3)
        3'b000, 3'b100: req_size = SZ_BYTE;
        3'b001, 3'b101: req_size = SZ_HALF;
        default:        req_size = SZ_WORD;
      endcase
    end
    req_uns = !bus.req_write && bus.req_funct3[2];
`ifdef LSU_MISALIGN_TRAP_EN
    req_mis = ((req_size == SZ_HALF) && bus.req_addr[0]) ||
              ((req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
`else
    req_mis = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      wr_q             <= 1'b0;
      size_q           <= SZ_WORD;
      uns_q            <= 1'b0;
      lane_q           <= 2'b00;
      wdata_q          <= '0;
      mem_address_q    <= '0;
      mem_data_write_q <= '0;
      resp_rdata_q     <= '0;
      resp_misalign_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      wr_q             <= wr_d;
      size_q           <= size_d;
      uns_q            <= uns_d;
      lane_q           <= lane_d;
      wdata_q          <= wdata_d;
      mem_address_q    <= mem_address_d;
      mem_data_write_q <= mem_data_write_d;
      resp_rdata_q     <= resp_rdata_d;
      resp_misalign_q  <= resp_misalign_d;
    end
  end

  // Response registers change only on entry to RESP so they hold between responses.
  always_comb begin
    state_d          = state_q;
    wr_d             = wr_q;
    size_d           = size_q;
    uns_d            = uns_q;
    lane_d           = lane_q;
    wdata_d          = wdata_q;
    mem_address_d    = mem_address_q;
    mem_data_write_d = mem_data_write_q;
    resp_rdata_d     = resp_rdata_q;
    resp_misalign_d  = resp_misalign_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          wr_d          = bus.req_write;
          size_d        = req_size;
          uns_d         = req_uns;
          lane_d        = bus.req_addr[1:0];
          wdata_d       = bus.req_wdata[15:0];
          mem_address_d = {{(WIDTH-DEPTH_LOG2){1'b0}}, bus.req_addr[DEPTH_LOG2+1:2]};
          if (req_mis) begin
            resp_rdata_d    = '0;
            resp_misalign_d = 1'b1;
            state_d         = S_RESP;
          end else if (bus.req_write && (req_size == SZ_WORD)) begin
            mem_data_write_d = bus.req_wdata;
            state_d          = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_READ:  state_d = S_MERGE;
      S_MERGE: begin
        if (wr_q) begin
          mem_data_write_d = store_merge(bus.mem_data_read, size_q, lane_q, wdata_q);
          state_d          = S_WRITE;
        end else begin
          resp_rdata_d    = load_ext(bus.mem_data_read, size_q, lane_q, uns_q);
          resp_misalign_d = 1'b0;
          state_d         = S_RESP;
        end
      end
      S_WRITE: begin
        resp_rdata_d    = '0;
        resp_misalign_d = 1'b0;
        state_d         = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready      = (state_q == S_IDLE);
    bus.mem_MemRead    = (state_q == S_READ);
    bus.mem_MemWrite   = (state_q == S_WRITE);
    bus.resp_valid     = (state_q == S_RESP);
    bus.resp_rdata     = resp_rdata_q;
    bus.resp_misalign  = resp_misalign_q;
    bus.mem_address    = mem_address_q;
    bus.mem_data_write = mem_data_write_q;
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a behavioural 1024-word registered-read memory.
module tb_lsu_mem_port;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  lsu_mem_port_if #(.WIDTH(32)) bus ();

  lsu_mem_port #(.WIDTH(32), .DEPTH_LOG2(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  bit          preloaded = 1'b0;
  int          wr_cnt    = 0;
  int          both_cnt  = 0;
  int          cyc       = 0;
  int          acc_q[$];

  always @(posedge clk) begin
    if (!preloaded) begin
      mem[4]    <= 32'h11223344;
      mem[5]    <= 32'h80FF7F01;
      preloaded <= 1'b1;
    end else begin
      if (bus.mem_MemWrite) mem[bus.mem_address[9:0]] <= bus.mem_data_write;
    end
    if (bus.mem_MemRead) bus.mem_data_read <= mem[bus.mem_address[9:0]];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_MemWrite) wr_cnt <= wr_cnt + 1;
    if (bus.mem_MemWrite && bus.mem_MemRead) both_cnt <= both_cnt + 1;
    if (!reset && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " req_ready"},      32'(bus.req_ready),     32'd1);
    chk({tag, " resp_valid"},     32'(bus.resp_valid),    32'd0);
    chk({tag, " resp_rdata"},     bus.resp_rdata,         32'd0);
    chk({tag, " resp_misalign"},  32'(bus.resp_misalign), 32'd0);
    chk({tag, " mem_address"},    bus.mem_address,        32'd0);
    chk({tag, " mem_data_write"}, bus.mem_data_write,     32'd0);
    chk({tag, " strobes"},        {30'd0, bus.mem_MemRead, bus.mem_MemWrite}, 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdat;
    logic [31:0] exp_maddr;
  } vec_t;

  function automatic vec_t mkv(logic wr, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                               logic [31:0] rdata, logic mis, int lat, int rd, int wrc,
                               logic [31:0] wdat, logic [31:0] maddr);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
    v.exp_mis = mis; v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wrc;
    v.exp_wdat = wdat; v.exp_maddr = maddr;
    return v;
  endfunction

  // Drive one request, wait for accept, then follow cycles 0.. until resp_valid.
  task automatic do_vec(input int idx, input vec_t v);
    int          lat, rd, wr;
    bit          rdy_seen, accepted;
    logic [31:0] wdat;
    string       t;
    t = $sformatf("v%0d", idx);
    bus.req_valid  = 1'b1;
    bus.req_write  = v.wr;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.req_ready) begin
        accepted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!accepted) begin
      chk({t, " accept timeout"}, 32'd0, 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    lat = -1; rd = -1; wr = -1; rdy_seen = 1'b0; wdat = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk({t, " mem_address"}, bus.mem_address, v.exp_maddr);
      if (bus.mem_MemRead && rd < 0) rd = c;
      if (bus.mem_MemWrite && wr < 0) begin
        wr   = c;
        wdat = bus.mem_data_write;
      end
      if (bus.req_ready) rdy_seen = 1'b1;
      if (bus.resp_valid) begin
        lat = c;
        chk({t, " resp_rdata"},    bus.resp_rdata,         v.exp_rdata);
        chk({t, " resp_misalign"}, 32'(bus.resp_misalign), 32'(v.exp_mis));
        break;
      end
    end
    chk({t, " resp cycle"},     32'(lat), 32'(v.exp_lat));
    chk({t, " read cycle"},     32'(rd),  32'(v.exp_rd));
    chk({t, " write cycle"},    32'(wr),  32'(v.exp_wr));
    chk({t, " ready while busy"}, 32'(rdy_seen), 32'd0);
    if (v.exp_wr >= 0) chk({t, " mem_data_write"}, wdat, v.exp_wdat);
    @(negedge clk);
    chk({t, " resp_valid one cycle"}, 32'(bus.resp_valid), 32'd0);
    chk({t, " rdata hold"},           bus.resp_rdata,      v.exp_rdata);
  endtask

  vec_t vecs[$];
  vec_t lw14;
  int   wr_before;
  bit   got2;

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    // wr, f3, addr, wdata, exp_rdata, mis, lat, rd, wr, wdat, maddr
    vecs.push_back(mkv(0, 3'b000, 32'h17, 0, 32'hFFFFFF80, 0, 2, 0, -1, 0, 5));
    vecs.push_back(mkv(0, 3'b100, 32'h17, 0, 32'h00000080, 0, 2, 0, -1, 0, 5));
    vecs.push_back(mkv(0, 3'b001, 32'h16, 0, 32'hFFFF80FF, 0, 2, 0, -1, 0, 5));
    vecs.push_back(mkv(0, 3'b101, 32'h14, 0, 32'h00007F01, 0, 2, 0, -1, 0, 5));
`ifdef LSU_MISALIGN_TRAP_EN
    vecs.push_back(mkv(0, 3'b010, 32'h13, 0, 32'h00000000, 1, 0, -1, -1, 0, 4));
`else
    vecs.push_back(mkv(0, 3'b010, 32'h13, 0, 32'h11223344, 0, 2, 0, -1, 0, 4));
`endif
    vecs.push_back(mkv(1, 3'b000, 32'h15, 32'h000000AB, 0, 0, 3, 0, 2, 32'h80FFAB01, 5));
    vecs.push_back(mkv(0, 3'b010, 32'h14, 0, 32'h80FFAB01, 0, 2, 0, -1, 0, 5));
    vecs.push_back(mkv(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 0, 1, -1, 0, 32'hDEADBEEF, 8));
    vecs.push_back(mkv(1, 3'b001, 32'h22, 32'hCAFE1234, 0, 0, 3, 0, 2, 32'h1234BEEF, 8));
    vecs.push_back(mkv(0, 3'b011, 32'h20, 0, 32'h1234BEEF, 0, 2, 0, -1, 0, 8));
    vecs.push_back(mkv(0, 3'b000, 32'h21, 0, 32'hFFFFFFBE, 0, 2, 0, -1, 0, 8));
    vecs.push_back(mkv(0, 3'b001, 32'h20, 0, 32'hFFFFBEEF, 0, 2, 0, -1, 0, 8));
    vecs.push_back(mkv(0, 3'b101, 32'h22, 0, 32'h00001234, 0, 2, 0, -1, 0, 8));
    vecs.push_back(mkv(1, 3'b011, 32'h24, 32'h01020304, 0, 0, 1, -1, 0, 32'h01020304, 9));
    vecs.push_back(mkv(0, 3'b100, 32'h26, 0, 32'h00000002, 0, 2, 0, -1, 0, 9));
    lw14 = mkv(0, 3'b010, 32'h14, 0, 32'h80FF7F01, 0, 2, 0, -1, 0, 5);

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Reset during MERGE of an SB must drop the write and leave word 5 untouched.
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h15;
    bus.req_wdata  = 32'h55;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    chk("rmw cycle0 MemRead", 32'(bus.mem_MemRead), 32'd1);
    @(negedge clk);
    chk("rmw merge MemRead", 32'(bus.mem_MemRead), 32'd0);
    wr_before = wr_cnt;
    reset = 1'b1;
    #1;
    chk_reset_outs("async reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no write after reset", 32'(wr_cnt), 32'(wr_before));
    do_vec(99, lw14);

    foreach (vecs[i]) do_vec(i, vecs[i]);

    // Back-to-back loads with req_valid held high.
    acc_q.delete();
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h14;
    got2 = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (acc_q.size() == 1) bus.req_addr = 32'h20;
      if (acc_q.size() >= 2) begin
        got2 = 1'b1;
        break;
      end
    end
    bus.req_valid = 1'b0;
    if (got2) chk("back-to-back spacing", 32'(acc_q[1] - acc_q[0]), 32'd4);
    else      chk("back-to-back accept timeout", 32'd0, 32'd1);
    repeat (5) @(negedge clk);
    chk("strobes never together", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
